// File: rtl/mock_mem_hs.sv
// Handshaked mock memory: request/response FSM with a fixed-latency wait and an error response.
// Optional write protection of the low ROM_WORDS words when MOCK_MEM_ROM_PROTECT_EN is defined.
module mock_mem_hs #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned ROM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

`ifdef MOCK_MEM_ROM_PROTECT_EN
    localparam bit ProtectEn = 1'b1;
`else
    localparam bit ProtectEn = 1'b0;
`endif

    localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] RomLim   = (ADDR_W + 1)'(ROM_WORDS);
    localparam logic [3:0]      LatInit  = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                enter_resp;
    logic                act_we;
    logic [ADDR_W-1:0]   act_addr;
    logic [DATA_W-1:0]   act_wdata;
    logic [IdxW-1:0]     act_idx;
    logic                act_err;

    // With zero latency the access happens on the accept edge, before the latches update.
    always_comb begin
        accept     = req_valid && (state_q == StIdle);
        enter_resp = (state_q != StResp) && (state_d == StResp);
        act_we     = (state_q == StIdle) ? req_we    : we_q;
        act_addr   = (state_q == StIdle) ? req_addr  : addr_q;
        act_wdata  = (state_q == StIdle) ? req_wdata : wdata_q;
        act_idx    = act_addr[IdxW-1:0];
        act_err    = ({1'b0, act_addr} >= DepthLim) ||
                     (ProtectEn && act_we && ({1'b0, act_addr} < RomLim));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = LatInit;
                    state_d = (LATENCY == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            mem_q[1] <= DATA_W'(1);
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= act_err;
            rdata_q <= (act_err || act_we) ? '0 : mem_q[act_idx];
            if (!act_err && act_we) begin
                mem_q[act_idx] <= act_wdata;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = (state_q == StResp) ? rdata_q : '0;
        rsp_err   = (state_q == StResp) ? err_q   : 1'b0;
    end

endmodule

// File: tb/tb_mock_mem_hs.sv
// Randomized bench for mock_mem_hs: a LATENCY=2 and a LATENCY=0 instance checked against an
// array-based memory model with per-transaction latency, backpressure and idle checks.
module tb_mock_mem_hs;

`ifdef MOCK_MEM_ROM_PROTECT_EN
    localparam bit Prot = 1'b1;
`else
    localparam bit Prot = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_wdata, rsp_rdata;

    logic [7:0]       mdl [2][128];
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    mock_mem_hs #(.LATENCY(2)) u_dut_lat2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mock_mem_hs #(.LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 128; i++) mdl[d][i] = 8'h00;
            mdl[d][1] = 8'h01;
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check_eq(tag, {rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]}, {1'b0, 1'b0, 8'h00, 1'b1});
    endtask

    // One full transaction: accept, latency count, response check, optional backpressure, idle.
    task automatic txn(input int d, input bit we, input logic [15:0] addr,
                       input logic [7:0] wdata, input int stall);
        logic [7:0] exp_rd;
        logic [7:0] held;
        bit         exp_err;
        int         cyc;
        int         lat;
        lat     = (d == 0) ? 2 : 0;
        exp_err = (addr >= 16'd128) || (Prot && we && addr < 16'd64);
        exp_rd  = (exp_err || we) ? 8'h00 : mdl[d][addr[6:0]];
        if (!exp_err && we) mdl[d][addr[6:0]] = wdata;

        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        cyc = 0;
        while (!req_ready[d] && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("accept_ready", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = 16'($urandom);
        req_wdata[d] = 8'($urandom);

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid[d] && cyc < 64);
        check_eq("latency", 32'(cyc), 32'(lat + 1));
        check_eq("rsp_rdata", 32'(rsp_rdata[d]), 32'(exp_rd));
        check_eq("rsp_err", 32'(rsp_err[d]), 32'(exp_err));

        held = rsp_rdata[d];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("bp_hold", {rsp_valid[d], req_ready[d], rsp_err[d], rsp_rdata[d]},
                     {1'b1, 1'b0, exp_err, held});
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        check_idle(d, "post_idle");
    endtask

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle(0, "reset_idle0");
        check_idle(1, "reset_idle1");
        rst_n = 1'b1;

        // Directed cases
        txn(0, 1'b0, 16'd1,   8'h00, 0);
        txn(0, 1'b1, 16'd100, 8'hA5, 0);
        txn(0, 1'b0, 16'd100, 8'h00, 0);
        txn(0, 1'b0, 16'd1,   8'h00, 5);
        txn(0, 1'b0, 16'd128, 8'h00, 0);
        txn(0, 1'b1, 16'd128, 8'h77, 1);
        txn(1, 1'b0, 16'd1,   8'h00, 0);
        txn(1, 1'b0, 16'd128, 8'h00, 0);
        txn(0, 1'b1, 16'd10,  8'hFF, 0);
        txn(0, 1'b0, 16'd10,  8'h00, 0);
        txn(0, 1'b1, 16'd127, 8'h3C, 0);
        txn(0, 1'b0, 16'd127, 8'h00, 2);

        // Random traffic, mostly in range
        for (int n = 0; n < 60; n++) begin
            int          d;
            logic [15:0] a;
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(128, 300))
                                            : 16'($urandom_range(0, 127));
            txn(d, 1'($urandom), a, 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset during WAIT of a write aborts it
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'd70;
        req_wdata[0] = 8'h5A;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("in_wait", {rsp_valid[0], req_ready[0]}, 2'b00);
        rst_n = 1'b0;
        #1;
        check_idle(0, "async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        txn(0, 1'b0, 16'd70, 8'h00, 0);
        txn(0, 1'b0, 16'd1,  8'h00, 0);
        txn(1, 1'b0, 16'd0,  8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mock_mem_hs.md
MOCK_MEM_HS -- requirements
Module: mock_mem_hs

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, request address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 128, number of words implemented; legal range 2..2^ADDR_W.
REQ-004 SHALL have parameter LATENCY, default 2, cycles spent in WAIT between request accept and response; legal range 0..15.
REQ-005 SHALL have parameter ROM_WORDS, default 64, words at addresses 0..ROM_WORDS-1 forming the protected region; legal range 0..DEPTH.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, block can accept a request.
REQ-010 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_W, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err, output, 1, access failed (out of range or protected).

Function
REQ-017 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-018 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready at a clock edge.
REQ-019 SHALL latch req_we, req_addr and req_wdata on accept; later changes on the request inputs SHALL have no effect on that transaction.
REQ-020 On accept, SHALL load a down-counter with LATENCY and go to WAIT; if LATENCY = 0, SHALL go directly to RESP.
REQ-021 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-022 Total latency SHALL be LATENCY+1 cycles from the accept edge to the first cycle with rsp_valid = 1.
REQ-023 On the edge entering RESP, SHALL perform the memory action and register rsp_rdata and rsp_err.
REQ-024 Read: SHALL return mem[addr]. Write: SHALL store wdata to mem[addr].
REQ-025 If the latched address is >= DEPTH, SHALL set rsp_err = 1 and rsp_rdata = 0, and SHALL leave memory unmodified.
REQ-026 In RESP, SHALL hold rsp_valid = 1 with rsp_rdata and rsp_err stable until rsp_ready = 1, then return to IDLE on that edge.
REQ-027 SHALL accept no new request in the cycle rsp_valid && rsp_ready completes; the earliest next accept is the following cycle (IDLE).
REQ-028 SHALL keep rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0 outside RESP.
REQ-029 SHALL hold memory contents indefinitely between accesses; reads SHALL have no side effects.

Reset
REQ-030 Reset SHALL force state IDLE, counter 0, req_ready = 1, rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0.
REQ-031 Reset SHALL load all words to 0, then word 0 = 8'h00 and word 1 = 8'h01 (zero-extended to DATA_W).
REQ-032 Reset asserted while in WAIT or RESP SHALL abort the transaction; no write from that transaction SHALL occur.

Configuration
REQ-033 Macro MOCK_MEM_ROM_PROTECT_EN: when defined, a write with addr < ROM_WORDS SHALL set rsp_err = 1 and leave memory unmodified.
REQ-034 When MOCK_MEM_ROM_PROTECT_EN is defined, reads in the protected region SHALL behave normally.
REQ-035 Without MOCK_MEM_ROM_PROTECT_EN, ROM_WORDS SHALL be ignored and all in-range writes SHALL succeed.

Verification
REQ-036 Read at reset: read addr 1 with LATENCY=2 -> rsp_valid on the 3rd cycle after accept, rsp_rdata=8'h01, rsp_err=0.
REQ-037 Write then read: write 8'hA5 to addr 100, then read addr 100 -> rsp_rdata=8'hA5, rsp_err=0 on both responses.
REQ-038 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; completes on the first cycle rsp_ready=1.
REQ-039 Range and latency: read addr 128 with DEPTH=128 -> rsp_err=1, rsp_rdata=0; with LATENCY=0, rsp_valid on the cycle after accept.
REQ-040 Protect and reset: with the macro defined, write 8'hFF to addr 10 -> rsp_err=1 and addr 10 still 0; rst_n low during WAIT of a write to addr 70 -> addr 70 stays 0.
